// File: rtl/pipe_stage_skid_if.sv
// Valid/ready bus for one pipeline stage: the upstream (in_*) and downstream
// (out_*) handshakes, grouped so the stage and its neighbours share one bundle.
// slave  : view taken by the stage itself.
// master : view taken by the surrounding environment (producer + consumer).
interface pipe_stage_skid_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, synchronous
// flush and a 2-entry skid buffer (main register = out_data, hidden skid
// register). in_ready comes straight from a flop, so no combinational path
// crosses the stage in either direction.
// Optional feature: define PIPE_STAGE_PERF_EN to add the stall_cnt port, a
// saturating count of cycles in which out_valid is held against !out_ready.
module pipe_stage_skid #(
    parameter int unsigned          WIDTH       = 32,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
    parameter int unsigned          CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 flush,
    pipe_stage_skid_if.slave     bus
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stateE;

    stateE            state;
    stateE            stateNext;
    logic [WIDTH-1:0] mainQ;
    logic [WIDTH-1:0] mainNext;
    logic [WIDTH-1:0] skidQ;
    logic [WIDTH-1:0] skidNext;
    logic             inReadyQ;
    logic             outValid;
    logic             acc;
    logic             ret;

    // Degenerate widths are rejected at elaboration.
    if (WIDTH < 1) begin : gBadWidth
        $error("pipe_stage_skid: WIDTH must be >= 1");
    end
    if (CNT_WIDTH < 1) begin : gBadCntWidth
        $error("pipe_stage_skid: CNT_WIDTH must be >= 1");
    end

    assign outValid      = (state != EMPTY);
    assign acc           = bus.in_valid & inReadyQ;
    assign ret           = outValid & bus.out_ready;

    assign bus.in_ready  = inReadyQ;
    assign bus.out_valid = outValid;
    assign bus.out_data  = mainQ;

    // Next-state and register-load decisions; flush overrides every transition.
    always_comb begin
        stateNext = state;
        mainNext  = mainQ;
        skidNext  = skidQ;
        if (flush) begin
            stateNext = EMPTY;
            mainNext  = RESET_VALUE;
            skidNext  = RESET_VALUE;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        stateNext = ONE;
                        mainNext  = bus.in_data;
                    end
                end
                ONE: begin
                    if (acc && ret) begin
                        mainNext  = bus.in_data;
                    end else if (acc) begin
                        stateNext = FULL;
                        skidNext  = bus.in_data;
                    end else if (ret) begin
                        stateNext = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (ret) begin
                        stateNext = ONE;
                        mainNext  = skidQ;
                    end
                end
                default: begin
                    stateNext = EMPTY;
                end
            endcase
        end
    end

    // State, payload registers and the registered in_ready.
    // in_ready is computed from the next state so it is already correct in the
    // cycle the state changes, without a combinational path from out_ready.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= EMPTY;
            mainQ    <= RESET_VALUE;
            skidQ    <= RESET_VALUE;
            inReadyQ <= 1'b1;
        end else begin
            state    <= stateNext;
            mainQ    <= mainNext;
            skidQ    <= skidNext;
            inReadyQ <= (stateNext != FULL);
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_WIDTH-1:0] stallCntQ;

    assign stall_cnt = stallCntQ;

    // Saturating backpressure counter; only reset clears it, flush does not.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stallCntQ <= '0;
        end else if (outValid && !bus.out_ready && (stallCntQ != '1)) begin
            stallCntQ <= stallCntQ + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (WIDTH=8, RESET_VALUE=0x5A,
// CNT_WIDTH=4). The stall counter checks run only when PIPE_STAGE_PERF_EN is
// defined for the build.
module tb_pipe_stage_skid;

    localparam int unsigned W  = 8;
    localparam logic [W-1:0] RV = 8'h5A;
    localparam int unsigned CW = 4;

    logic clk;
    logic n_rst;
    logic flush;
    int   nCompared;
    int   nMismatched;

    pipe_stage_skid_if #(.WIDTH(W)) bus ();

`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_cnt;
`endif

    pipe_stage_skid #(
        .WIDTH      (W),
        .RESET_VALUE(RV),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .flush    (flush),
        .bus      (bus)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic rdy);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = rdy;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        n_rst       = 1'b0;
        flush       = 1'b0;
        drive(1'b0, 8'h00, 1'b0);

        // 1: reset held for 3 clocks
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        checkVal("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkVal("rst_in_ready",  32'(bus.in_ready),  32'd1);
        checkVal("rst_out_data",  32'(bus.out_data),  32'(RV));
`ifdef PIPE_STAGE_PERF_EN
        checkVal("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

        // 2: streaming with out_ready=1
        drive(1'b1, 8'h11, 1'b1); tick();
        checkVal("stream_d0", 32'(bus.out_data), 32'h11);
        checkVal("stream_v0", 32'(bus.out_valid), 32'd1);
        checkVal("stream_r0", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 8'h22, 1'b1); tick();
        checkVal("stream_d1", 32'(bus.out_data), 32'h22);
        checkVal("stream_r1", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 8'h33, 1'b1); tick();
        checkVal("stream_d2", 32'(bus.out_data), 32'h33);
        checkVal("stream_r2", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 8'h00, 1'b1); tick();
        checkVal("stream_drain_v", 32'(bus.out_valid), 32'd0);
        checkVal("stream_hold_d",  32'(bus.out_data), 32'h33);

        // 3: backpressure fills the skid, then drains in order
        drive(1'b1, 8'hA1, 1'b0); tick();
        checkVal("bp_one_d", 32'(bus.out_data), 32'hA1);
        checkVal("bp_one_r", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 8'hA2, 1'b0); tick();
        checkVal("bp_full_r", 32'(bus.in_ready), 32'd0);
        checkVal("bp_full_d", 32'(bus.out_data), 32'hA1);
        drive(1'b1, 8'hA3, 1'b0); tick();
        checkVal("bp_hold_r", 32'(bus.in_ready), 32'd0);
        checkVal("bp_hold_v", 32'(bus.out_valid), 32'd1);
        checkVal("bp_hold_d", 32'(bus.out_data), 32'hA1);
        drive(1'b1, 8'hA3, 1'b1); tick();
        checkVal("bp_drain_d1", 32'(bus.out_data), 32'hA2);
        checkVal("bp_drain_r1", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 8'hA3, 1'b1); tick();
        checkVal("bp_drain_d2", 32'(bus.out_data), 32'hA3);
        checkVal("bp_drain_v2", 32'(bus.out_valid), 32'd1);
        drive(1'b0, 8'h00, 1'b0); tick();
        checkVal("bp_idle_hold_v", 32'(bus.out_valid), 32'd1);
        checkVal("bp_idle_hold_d", 32'(bus.out_data), 32'hA3);
        drive(1'b0, 8'h00, 1'b1); tick();
        checkVal("bp_empty_v", 32'(bus.out_valid), 32'd0);

        // 4: flush while FULL with a beat on offer
        drive(1'b1, 8'hC1, 1'b0); tick();
        drive(1'b1, 8'hC2, 1'b0); tick();
        checkVal("fl_pre_r", 32'(bus.in_ready), 32'd0);
        flush = 1'b1;
        drive(1'b1, 8'hBB, 1'b0); tick();
        flush = 1'b0;
        checkVal("fl_v", 32'(bus.out_valid), 32'd0);
        checkVal("fl_r", 32'(bus.in_ready), 32'd1);
        checkVal("fl_d", 32'(bus.out_data), 32'(RV));
        drive(1'b0, 8'h00, 1'b1); tick();
        checkVal("fl_post_v", 32'(bus.out_valid), 32'd0);
        checkVal("fl_post_d", 32'(bus.out_data), 32'(RV));

        // 5: async reset asserted mid-cycle while FULL
        drive(1'b1, 8'hD1, 1'b0); tick();
        drive(1'b1, 8'hD2, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0);
        checkVal("ar_pre_v", 32'(bus.out_valid), 32'd1);
        #2;
        n_rst = 1'b0;
        #1;
        checkVal("ar_v", 32'(bus.out_valid), 32'd0);
        checkVal("ar_r", 32'(bus.in_ready),  32'd1);
        checkVal("ar_d", 32'(bus.out_data),  32'(RV));
        tick();
        n_rst = 1'b1;
        tick();
        checkVal("ar_rel_v", 32'(bus.out_valid), 32'd0);
        checkVal("ar_rel_r", 32'(bus.in_ready),  32'd1);
        drive(1'b1, 8'hE1, 1'b1); tick();
        checkVal("ar_resume_d", 32'(bus.out_data), 32'hE1);
        drive(1'b0, 8'h00, 1'b1); tick();

`ifdef PIPE_STAGE_PERF_EN
        // 6: stall counter saturation, flush keeps it, reset clears it
        checkVal("pc_start", 32'(stall_cnt), 32'd0);
        drive(1'b1, 8'hF1, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0);
        repeat (20) tick();
        checkVal("pc_sat", 32'(stall_cnt), 32'd15);
        flush = 1'b1; tick(); flush = 1'b0;
        checkVal("pc_flush", 32'(stall_cnt), 32'd15);
        #2;
        n_rst = 1'b0;
        #1;
        checkVal("pc_reset", 32'(stall_cnt), 32'd0);
        tick();
        n_rst = 1'b1;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, compared %0d", nCompared);
        $fatal(1, "timeout");
    end

endmodule
